vblank_update_scheduler: RTL and testbench
==========================================

# vblank_update_scheduler

Frame-update scheduler for the 800x600@60 display pipeline. It watches the blanking flag from the VGA timing bus, and at each vertical-blank start it grants a one-cycle start strobe to each enabled game-logic client in turn (car physics, collision, score, sprite table, …). It waits for each client's done handshake or a timeout, so clients never update shared state during active video. It reports per-frame timeouts and vblank overruns for debug LEDs and the ILA.

## Interface
Parameters:
- N_CLIENTS, 4, number of requesters; client 0 has highest priority (serviced first).
- TIMEOUT, 1024, maximum WAIT cycles per client before it is abandoned; ≥2.

Ports:
- pclk  input  1  40 MHz pixel clock. This is the only clock.
- rst  input  1  reset. Reset is synchronous and active-high.
- vblnk_in  input  1  vertical blank flag taken from the VGA bus.
- enable_in  input  N_CLIENTS  client mask, sampled in SCAN.
- done_in  input  N_CLIENTS  client completion, level or pulse; sampled only in WAIT for the current client.
- start_out  output  N_CLIENTS  one-hot, one-cycle start strobe.
- busy_out  output  1  high from frame start until the sequence ends.
- frame_cnt_out  output  16  count of frames started; wraps from 65535 to 0.
- timeout_out  output  N_CLIENTS  sticky per frame; bit k set if client k timed out.
- overrun_out  output  1  sticky per frame; set if vblank ended, or a new vblank began, while busy.

## Operation
- Edge detect: vblnk_d <= vblnk_in. frame_start = vblnk_in & ~vblnk_d.
- FSM states: IDLE, SCAN, START, WAIT. idx has width clog2(N_CLIENTS+1). timer has width clog2(TIMEOUT).
- IDLE, on frame_start:
  - frame_cnt_out++, timeout_out <= 0, overrun_out <= 0, idx <= 0, busy_out <= 1.
  - Go to SCAN.
- SCAN:
  - If idx == N_CLIENTS: busy_out <= 0, go to IDLE.
  - Else if enable_in[idx]: timer <= 0, go to START.
  - Else: idx++, stay in SCAN (one cycle per skipped client).
- START:
  - start_out[idx] = 1. It is decoded from registered state and idx only, and is high for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - If done_in[idx]: idx++, go to SCAN.
  - Else if timer == TIMEOUT-1: timeout_out[idx] <= 1, idx++, go to SCAN.
  - Else: timer++.
  - done_in for other clients is ignored. done_in[idx] seen during START is ignored.
- Overrun: in any state other than IDLE, overrun_out <= 1 if vblnk_in == 0 or frame_start occurs.
  - The sequence still runs to completion.
  - A frame_start seen while busy does not restart the sequence, and frame_cnt_out does not increment. That frame is lost.
- Simultaneous events:
  - done_in[idx] and timer == TIMEOUT-1 in the same cycle: done wins, and no timeout bit is set.
  - The busy_out deassert cycle and frame_start in the same cycle cannot both act, because frame_start is only acted on in IDLE.
- Clearing: timeout_out and overrun_out clear only at an accepted frame start, or on reset.

## Timing
- Reset values:
  - State IDLE, idx 0, timer 0.
  - start_out 0, busy_out 0, frame_cnt_out 0, timeout_out 0, overrun_out 0.
  - vblnk_d = 1. A vblank already in progress at reset release is not treated as a frame start.
- Reset mid-operation: start_out and busy_out are 0 in the cycle after rst is sampled high. The partial sequence is abandoned.
- Latency:
  - Let frame_start be sampled at edge E0.
  - busy_out is high after E0.
  - If client 0 is enabled, start_out[0] is high during the cycle after E1.
  - The earliest accepted done_in[0] is in the cycle after E2.
- Per-client cost:
  - Enabled client: 2 + w cycles, where w is the number of WAIT cycles (1..TIMEOUT).
  - Disabled client: 1 cycle.
  - End of sequence: 1 extra SCAN cycle before IDLE.
- Worst case: N_CLIENTS*(2+TIMEOUT)+1 cycles. This must fit in 28 lines × 1056 pclk = 29568 cycles of vblank at default parameters.

## Test plan
- Reset/idle:
  - Stimulus: hold rst with vblnk_in=1, then release.
  - Required: no start_out and frame_cnt_out stays 0. The next real 0→1 transition gives frame_cnt_out=1 and start_out[0] pulse two cycles after the edge sample.
- All clients fast:
  - Stimulus: enable=4'b1111, each done_in[k] returned the first WAIT cycle.
  - Required: start_out pulses 0,1,2,3 spaced 3 cycles apart, busy_out low 13 cycles after frame start, no flags.
- Masking:
  - Stimulus: enable=4'b1010.
  - Required: only start_out[1] and start_out[3] pulse. Skipped clients cost one cycle each, confirmed by the pulse timing.
- Timeout:
  - Stimulus: TIMEOUT=16, client 2 never asserts done.
  - Required: client 3 starts 16 WAIT cycles later, timeout_out=4'b0100, and timeout_out clears at the next frame start.
- Overrun/lost frame:
  - Stimulus: drop vblnk_in while client 1 is in WAIT, then raise it again while still busy.
  - Required: overrun_out=1, the sequence completes, frame_cnt_out does not increment for the second edge.
- Reset mid-WAIT, and done vs timeout tie:
  - Stimulus: assert rst during WAIT. Separately, assert done_in exactly at timer=TIMEOUT-1.
  - Required: all outputs 0 the next cycle. For the tie, the client counts as done and its timeout bit is not set.

Source files
------------

// File: rtl/vblank_update_scheduler_if.sv
// VGA-blank / game-client handshake bundle for the vblank update scheduler.
interface vblank_update_scheduler_if #(
  parameter int unsigned N_CLIENTS = 4
);
  logic                 vblnk_in;
  logic [N_CLIENTS-1:0] enable_in;
  logic [N_CLIENTS-1:0] done_in;
  logic [N_CLIENTS-1:0] start_out;
  logic                 busy_out;
  logic [15:0]          frame_cnt_out;
  logic [N_CLIENTS-1:0] timeout_out;
  logic                 overrun_out;

  modport master (
    output vblnk_in, enable_in, done_in,
    input  start_out, busy_out, frame_cnt_out, timeout_out, overrun_out
  );

  modport slave (
    input  vblnk_in, enable_in, done_in,
    output start_out, busy_out, frame_cnt_out, timeout_out, overrun_out
  );
endinterface

// File: rtl/vblank_update_scheduler.sv
// Grants each enabled game-logic client one start strobe per vertical blank,
// in priority order, waiting for done or a timeout before moving on.
module vblank_update_scheduler #(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic pclk,
  input logic rst,
  vblank_update_scheduler_if.slave bus
);

  localparam int unsigned IW = $clog2(N_CLIENTS + 1);
  localparam int unsigned SW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [N_CLIENTS-1:0] ONE = N_CLIENTS'(1);

  typedef enum logic [1:0] {IDLE, SCAN, START, WAIT} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [SW-1:0] sel;
  logic [TW-1:0] timer;
  logic          vblnk_d;
  logic          frame_start;

  assign frame_start = bus.vblnk_in & ~vblnk_d;
  // idx only reaches N_CLIENTS in SCAN, where it is tested before any indexing
  assign sel = idx[SW-1:0];

  always_ff @(posedge pclk) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      timer             <= '0;
      vblnk_d           <= 1'b1;
      bus.start_out     <= '0;
      bus.busy_out      <= 1'b0;
      bus.frame_cnt_out <= '0;
      bus.timeout_out   <= '0;
      bus.overrun_out   <= 1'b0;
    end else begin
      vblnk_d       <= bus.vblnk_in;
      bus.start_out <= '0;

      if (state != IDLE && (!bus.vblnk_in || frame_start))
        bus.overrun_out <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            bus.frame_cnt_out <= bus.frame_cnt_out + 16'd1;
            bus.timeout_out   <= '0;
            bus.overrun_out   <= 1'b0;
            bus.busy_out      <= 1'b1;
            idx               <= '0;
            state             <= SCAN;
          end
        end

        SCAN: begin
          if (idx == IW'(N_CLIENTS)) begin
            bus.busy_out <= 1'b0;
            state        <= IDLE;
          end else if (bus.enable_in[sel]) begin
            // strobe is registered here so it is high exactly while in START
            timer         <= '0;
            bus.start_out <= ONE << sel;
            state         <= START;
          end else begin
            idx <= idx + IW'(1);
          end
        end

        START: state <= WAIT;

        WAIT: begin
          if (bus.done_in[sel]) begin
            idx   <= idx + IW'(1);
            state <= SCAN;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            bus.timeout_out[sel] <= 1'b1;
            idx                  <= idx + IW'(1);
            state                <= SCAN;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Self-checking bench: per-frame vector table with a start-strobe scoreboard,
// plus hand sequences for reset behaviour.
module tb_vblank_update_scheduler;

  localparam int NC      = 4;
  localparam int TIMEOUT = 16;
  localparam int BUDGET  = 200;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  always #5 pclk = ~pclk;

  vblank_update_scheduler_if #(.N_CLIENTS(NC)) bus ();

  vblank_update_scheduler #(.N_CLIENTS(NC), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus.slave)
  );

  // lat[k]: WAIT cycle (1-based) in which done_in[k] pulses; 0 = never
  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][7:0] lat;
    logic [7:0]      drop_at;
    logic [7:0]      rise_at;
    logic [7:0]      busy_end;
    logic [3:0]      exp_to;
    logic            exp_ovr;
  } vec_t;

  typedef struct {
    int client;
    int cyc;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Cycle c = number of posedges since the one that sampled the vblank rise.
  task automatic run_frame(input vec_t v);
    sb_t e;
    int  t, d, w, k, ts, fall;
    bit  act;
    t = 1;
    for (int unsigned i = 0; i < NC; i++) begin
      if (v.en[i]) begin
        d = int'(v.lat[i]);
        w = (d >= 1 && d <= TIMEOUT) ? d : TIMEOUT;
        sb_q.push_back('{client: int'(i), cyc: t});
        t += 2 + w;
      end else begin
        t += 1;
      end
    end
    bus.enable_in = v.en;
    bus.vblnk_in  = 1'b1;
    exp_cnt++;
    act = 0; k = 0; ts = 0; fall = -1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge pclk);
      if (c == 0) chk("busy_rise", 32'(bus.busy_out), 32'd1);
      if (bus.start_out != '0) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL start_unexpected cycle=%0d actual=%b required=none", c, bus.start_out);
        end else begin
          e = sb_q.pop_front();
          chk("start_client", 32'(bus.start_out), 32'(4'b0001 << e.client));
          chk("start_cycle", 32'(c), 32'(e.cyc));
          act = 1; k = e.client; ts = c;
        end
      end
      if (fall < 0 && !bus.busy_out) fall = c;
      bus.done_in = (act && v.lat[k] != 8'd0 && c == ts + int'(v.lat[k])) ? (4'b0001 << k) : 4'b0000;
      if (v.drop_at != 8'd0 && c == int'(v.drop_at)) bus.vblnk_in = 1'b0;
      if (v.rise_at != 8'd0 && c == int'(v.rise_at)) bus.vblnk_in = 1'b1;
      if (fall >= 0 && c >= fall + 2) break;
    end
    chk("busy_fall_cycle", 32'(fall), 32'(v.busy_end));
    chk("timeout_flags", 32'(bus.timeout_out), 32'(v.exp_to));
    chk("overrun_flag", 32'(bus.overrun_out), 32'(v.exp_ovr));
    chk("frame_cnt", 32'(bus.frame_cnt_out), 32'(exp_cnt[15:0]));
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    bus.vblnk_in = 1'b0;
    bus.done_in  = '0;
    repeat (3) @(negedge pclk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{en: 4'b1111, lat: {8'd1, 8'd1, 8'd1, 8'd1}, drop_at: 8'd0, rise_at: 8'd0,
                busy_end: 8'd13, exp_to: 4'b0000, exp_ovr: 1'b0};
    vecs[1] = '{en: 4'b1010, lat: {8'd1, 8'd1, 8'd1, 8'd1}, drop_at: 8'd0, rise_at: 8'd0,
                busy_end: 8'd9, exp_to: 4'b0000, exp_ovr: 1'b0};
    vecs[2] = '{en: 4'b1111, lat: {8'd1, 8'd0, 8'd1, 8'd1}, drop_at: 8'd0, rise_at: 8'd0,
                busy_end: 8'd28, exp_to: 4'b0100, exp_ovr: 1'b0};
    vecs[3] = vecs[0];
    vecs[4] = '{en: 4'b0011, lat: {8'd0, 8'd0, 8'd17, 8'd16}, drop_at: 8'd0, rise_at: 8'd0,
                busy_end: 8'd39, exp_to: 4'b0010, exp_ovr: 1'b0};
    vecs[5] = '{en: 4'b0000, lat: {8'd1, 8'd1, 8'd1, 8'd1}, drop_at: 8'd0, rise_at: 8'd0,
                busy_end: 8'd5, exp_to: 4'b0000, exp_ovr: 1'b0};
    vecs[6] = '{en: 4'b1111, lat: {8'd1, 8'd1, 8'd5, 8'd1}, drop_at: 8'd6, rise_at: 8'd8,
                busy_end: 8'd17, exp_to: 4'b0000, exp_ovr: 1'b1};
    vecs[7] = vecs[0];

    bus.vblnk_in  = 1'b1;
    bus.enable_in = 4'b1111;
    bus.done_in   = '0;
    rst           = 1'b1;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    // vblank already high at release must not start a frame
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("idle_outputs", 32'({bus.start_out, bus.busy_out, bus.frame_cnt_out,
                               bus.timeout_out, bus.overrun_out}), 32'd0);
    end
    bus.vblnk_in = 1'b0;
    repeat (2) @(negedge pclk);

    for (int unsigned i = 0; i < 8; i++) run_frame(vecs[i]);

    // Reset in the middle of WAIT, after an overrun was flagged
    bus.enable_in = 4'b0001;
    bus.done_in   = '0;
    bus.vblnk_in  = 1'b1;
    repeat (4) @(negedge pclk);
    bus.vblnk_in = 1'b0;
    @(negedge pclk);
    chk("ovr_before_rst", 32'({bus.busy_out, bus.overrun_out}), 32'b11);
    rst = 1'b1;
    @(negedge pclk);
    chk("rst_outputs", 32'({bus.start_out, bus.busy_out, bus.frame_cnt_out,
                            bus.timeout_out, bus.overrun_out}), 32'd0);
    bus.vblnk_in = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    exp_cnt = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("post_rst_idle", 32'({bus.start_out, bus.busy_out, bus.frame_cnt_out}), 32'd0);
    end
    bus.vblnk_in = 1'b0;
    repeat (2) @(negedge pclk);
    run_frame(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
